// File: rtl/spi_bus_arbiter_if.sv
// Bundle of client-side inputs and board-side outputs of the SPI bus arbiter.
interface spi_bus_arbiter_if;
  logic [2:0] req;
  logic [2:0] c_sck;
  logic [2:0] c_mosi;
  logic       c_amp_cs;
  logic       c_ad_conv;
  logic       c_dac_cs;
  logic [2:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic       spi_sck;
  logic       spi_mosi;
  logic       amp_cs;
  logic       ad_conv;
  logic       dac_cs;
  logic       spi_ss_b;
  logic       sf_ce0;
  logic       fpga_init_b;
  logic       timeout_err;
  logic [1:0] err_id;

  modport master (
    output req, c_sck, c_mosi, c_amp_cs, c_ad_conv, c_dac_cs,
    input  grant, owner, busy, spi_sck, spi_mosi, amp_cs, ad_conv, dac_cs,
           spi_ss_b, sf_ce0, fpga_init_b, timeout_err, err_id
  );

  modport slave (
    input  req, c_sck, c_mosi, c_amp_cs, c_ad_conv, c_dac_cs,
    output grant, owner, busy, spi_sck, spi_mosi, amp_cs, ad_conv, dac_cs,
           spi_ss_b, sf_ce0, fpga_init_b, timeout_err, err_id
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI bus among three clients, with a guard
// gap between owners and a hold-time watchdog that forces a release.
module spi_bus_arbiter #(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 4095
) (
  input  logic             clk,
  input  logic             rst,
  spi_bus_arbiter_if.slave bus
);

  localparam int unsigned NCLI    = 3;
  localparam int unsigned HOLD_W  = 12;
  localparam int unsigned GUARD_W = 4;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(TIMEOUT - 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);
  localparam logic [1:0]         NO_OWNER   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          grant_q, grant_d;
  logic [1:0]          owner_q, owner_d;
  logic [1:0]          last_q, last_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [GUARD_W-1:0]  guard_q, guard_d;
  logic                timeout_err_q, timeout_err_d;
  logic [1:0]          err_id_q, err_id_d;
  logic [2:0]          blocked_q, blocked_d;

  logic [2:0]          eligible_c;
  logic [1:0]          cand_c;
  logic [1:0]          winner_c;
  logic                win_vld_c;

  // Round-robin pick starting one past the previous owner; forced clients are masked.
  always_comb begin
    eligible_c = bus.req & ~blocked_q;
    cand_c     = 2'd0;
    winner_c   = 2'd0;
    win_vld_c  = 1'b0;
    for (int k = 1; k <= int'(NCLI); k++) begin
      cand_c = 2'((int'(last_q) + k) % int'(NCLI));
      if (!win_vld_c && eligible_c[cand_c]) begin
        win_vld_c = 1'b1;
        winner_c  = cand_c;
      end
    end
  end

  // Next-state logic: grant, release/timeout, guard countdown.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_d        = last_q;
    hold_d        = hold_q;
    guard_d       = guard_q;
    timeout_err_d = timeout_err_q;
    err_id_d      = err_id_q;
    blocked_d     = blocked_q & bus.req;

    case (state_q)
      ST_IDLE: begin
        if (win_vld_c) begin
          state_d = ST_OWN;
          grant_d = 3'b001 << winner_c;
          owner_d = winner_c;
          last_d  = winner_c;
          hold_d  = '0;
        end
      end
      ST_OWN: begin
        hold_d = hold_q + HOLD_W'(1);
        if (!bus.req[owner_q] || (hold_q == HOLD_LAST)) begin
          state_d = ST_GUARD;
          grant_d = 3'b000;
          owner_d = NO_OWNER;
          guard_d = '0;
          // A release in the timeout cycle wins over the error.
          if (bus.req[owner_q]) begin
            timeout_err_d       = 1'b1;
            err_id_d            = owner_q;
            blocked_d[owner_q]  = 1'b1;
          end
        end
      end
      ST_GUARD: begin
        if (guard_q == GUARD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          guard_d = guard_q + GUARD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 3'b000;
        owner_d = NO_OWNER;
      end
    endcase
  end

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= 3'b000;
      owner_q       <= NO_OWNER;
      last_q        <= 2'd2;
      hold_q        <= '0;
      guard_q       <= '0;
      timeout_err_q <= 1'b0;
      err_id_q      <= 2'd0;
      blocked_q     <= 3'b000;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      hold_q        <= hold_d;
      guard_q       <= guard_d;
      timeout_err_q <= timeout_err_d;
      err_id_q      <= err_id_d;
      blocked_q     <= blocked_d;
    end
  end

  // Bus mux: the owner's signals pass straight through, everything else idles.
  always_comb begin
    bus.spi_sck  = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.amp_cs   = 1'b1;
    bus.ad_conv  = 1'b0;
    bus.dac_cs   = 1'b1;
    if (state_q == ST_OWN) begin
      bus.spi_sck  = bus.c_sck[owner_q];
      bus.spi_mosi = bus.c_mosi[owner_q];
      case (owner_q)
        2'd0:    bus.amp_cs  = bus.c_amp_cs;
        2'd1:    bus.ad_conv = bus.c_ad_conv;
        2'd2:    bus.dac_cs  = bus.c_dac_cs;
        default: ;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.owner       = owner_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.timeout_err = timeout_err_q;
  assign bus.err_id      = err_id_q;
  assign bus.spi_ss_b    = 1'b1;
  assign bus.sf_ce0      = 1'b1;
  assign bus.fpga_init_b = 1'b0;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a behavioural model of the arbitration rules.
module tb_spi_bus_arbiter;

  localparam int unsigned GUARD = 4;
  localparam int unsigned TMO   = 4095;

  logic clk = 1'b0;
  logic rst;

  always #10 clk = ~clk;

  spi_bus_arbiter_if bus();

  spi_bus_arbiter #(.GUARD_CYCLES(GUARD), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model: owner index (-1 = none), guard cycles still to run, OWN cycles elapsed.
  int m_owner, m_guard_left, m_held, m_last, m_err, m_err_id, m_c;
  bit m_blocked [3];

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_guard_left = 0; m_held = 0; m_last = 2;
      m_err = 0; m_err_id = 0;
      for (int i = 0; i < 3; i++) m_blocked[i] = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) if (!bus.req[i]) m_blocked[i] = 1'b0;
      if (m_owner >= 0) begin
        m_held++;
        if (!bus.req[m_owner]) begin
          m_owner = -1; m_guard_left = GUARD;
        end else if (m_held == TMO) begin
          m_err = 1; m_err_id = m_owner; m_blocked[m_owner] = 1'b1;
          m_owner = -1; m_guard_left = GUARD;
        end
      end else if (m_guard_left > 0) begin
        m_guard_left--;
      end else begin
        for (int k = 1; k <= 3; k++) begin
          m_c = (m_last + k) % 3;
          if (m_owner < 0 && bus.req[m_c] && !m_blocked[m_c]) begin
            m_owner = m_c; m_last = m_c; m_held = 0;
          end
        end
      end
    end
  end

  function automatic logic [16:0] model_vec();
    logic [2:0] g;
    logic [1:0] o;
    logic bsy, sck, mosi, amp, adc, dac;
    g    = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    o    = (m_owner >= 0) ? 2'(m_owner) : 2'd3;
    bsy  = (m_owner >= 0) || (m_guard_left > 0);
    sck  = (m_owner >= 0) ? bus.c_sck[m_owner]  : 1'b0;
    mosi = (m_owner >= 0) ? bus.c_mosi[m_owner] : 1'b0;
    amp  = (m_owner == 0) ? bus.c_amp_cs  : 1'b1;
    adc  = (m_owner == 1) ? bus.c_ad_conv : 1'b0;
    dac  = (m_owner == 2) ? bus.c_dac_cs  : 1'b1;
    return {g, o, bsy, sck, mosi, amp, adc, dac, 1'b1, 1'b1, 1'b0, 1'(m_err), 2'(m_err_id)};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {bus.grant, bus.owner, bus.busy, bus.spi_sck, bus.spi_mosi, bus.amp_cs,
            bus.ad_conv, bus.dac_cs, bus.spi_ss_b, bus.sf_ce0, bus.fpga_init_b,
            bus.timeout_err, bus.err_id};
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("cycle", 32'(dut_vec()), 32'(model_vec()));
      chk("onehot", 32'($countones(bus.grant) <= 1), 32'd1);
    end
  end

  task automatic wait_grant(input string tag, input logic [2:0] g, input int limit);
    int n = 0;
    while (bus.grant !== g && n < limit) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, 32'(bus.grant), 32'(g));
  endtask

  task automatic idle_bus();
    bus.req = 3'b000;
    repeat (GUARD + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int cnt;
    rst = 1'b1;
    bus.req = 3'b111; bus.c_sck = 3'b000; bus.c_mosi = 3'b000;
    bus.c_amp_cs = 1'b1; bus.c_ad_conv = 1'b0; bus.c_dac_cs = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd3);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_err",   32'(bus.timeout_err), 32'd0);

    // Reset with all requesting: client0 first, then client1 after the guard.
    rst = 1'b0;
    @(posedge clk); #1;
    chk("first_grant", 32'(bus.grant), 32'b001);
    bus.req = 3'b110;
    @(posedge clk); #1;
    chk("release_grant", 32'(bus.grant), 32'd0);
    chk("release_busy",  32'(bus.busy), 32'd1);
    n = 0;
    while (bus.grant != 3'b010 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("regrant_latency", 32'(n), 32'd5);

    // Client1 owns: only its convert pulse reaches the board.
    bus.c_amp_cs = 1'b0; bus.c_dac_cs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.c_ad_conv = 1'(i % 2);
      #1;
      chk("adc_follow", 32'(bus.ad_conv), 32'(i % 2));
      chk("amp_held",   32'(bus.amp_cs), 32'd1);
      chk("dac_held",   32'(bus.dac_cs), 32'd1);
      @(posedge clk); #1;
    end
    bus.req = 3'b100;
    wait_grant("pending_client2", 3'b100, 20);
    bus.c_amp_cs = 1'b1; bus.c_dac_cs = 1'b1; bus.c_ad_conv = 1'b0;
    idle_bus();

    // Release exactly in the timeout cycle: normal release, no error.
    bus.req = 3'b001;
    wait_grant("edge_grant", 3'b001, 20);
    repeat (TMO - 1) @(posedge clk);
    #1 bus.req = 3'b000;
    @(posedge clk); #1;
    chk("edge_grant_off", 32'(bus.grant), 32'd0);
    chk("edge_busy",      32'(bus.busy), 32'd1);
    chk("edge_no_err",    32'(bus.timeout_err), 32'd0);
    idle_bus();

    // Client2 hogs the bus: forced release, sticky error, blocked until it drops.
    bus.req = 3'b100;
    wait_grant("hog_grant", 3'b100, 20);
    cnt = 1;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (bus.grant == 3'b100) cnt++;
    end
    chk("hog_cycles",  32'(cnt), 32'(TMO));
    chk("hog_err",     32'(bus.timeout_err), 32'd1);
    chk("hog_err_id",  32'(bus.err_id), 32'd2);
    chk("hog_blocked", 32'(bus.grant), 32'd0);
    bus.req = 3'b000;
    @(posedge clk); #1;
    bus.req = 3'b100;
    wait_grant("hog_regrant", 3'b100, 5);
    idle_bus();

    // Reset during a transfer with a live clock on the owner.
    bus.req = 3'b001;
    wait_grant("mid_grant", 3'b001, 20);
    bus.c_sck = 3'b111; bus.c_amp_cs = 1'b0;
    #1 chk("mid_sck_pass", 32'(bus.spi_sck), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_sck",   32'(bus.spi_sck), 32'd0);
    chk("mid_rst_grant", 32'(bus.grant), 32'd0);
    chk("mid_rst_amp",   32'(bus.amp_cs), 32'd1);
    chk("mid_rst_dac",   32'(bus.dac_cs), 32'd1);
    chk("mid_rst_err",   32'(bus.timeout_err), 32'd0);
    rst = 1'b0; bus.c_sck = 3'b000; bus.c_amp_cs = 1'b1;
    idle_bus();

    // With last owner 0, a simultaneous 101 request goes to client2 first.
    bus.req = 3'b001;
    wait_grant("rr_setup", 3'b001, 20);
    idle_bus();
    bus.req = 3'b101;
    @(posedge clk); #1;
    chk("rr_client2_first", 32'(bus.grant), 32'b100);
    bus.req = 3'b001;
    wait_grant("rr_client0_next", 3'b001, 20);
    idle_bus();

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
        if ($urandom_range(15) == 0) bus.req[i] = ~bus.req[i];
      bus.c_sck     = 3'($urandom);
      bus.c_mosi    = 3'($urandom);
      bus.c_amp_cs  = 1'($urandom);
      bus.c_ad_conv = 1'($urandom);
      bus.c_dac_cs  = 1'($urandom);
      rst = ($urandom_range(499) == 0);
    end
    rst = 1'b0;
    bus.req = 3'b000;
    repeat (GUARD + 3) @(posedge clk);
    #1 mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
